// File: rtl/spi_master_mc_if.sv
// Bundles the configuration, stream handshake, status and SPI pin signals of spi_master_mc.
// The master modport is the controller's view; the slave modport is the environment's view.
interface spi_master_mc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 4,
    parameter int unsigned SS_W   = 2,
    parameter int unsigned DIV_W  = 8
);
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic              cfg_lsb_first;
    logic [DIV_W-1:0]  cfg_div;
    logic [SS_W-1:0]   cfg_ss_sel;
    logic              cfg_loopback;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done_irq;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_ss_sel, cfg_loopback,
        input  tx_valid, tx_data, tx_last, miso,
        output tx_ready, rx_valid, rx_data, busy, done_irq, sck, mosi, ss_n
    );

    modport slave (
        output cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_ss_sel, cfg_loopback,
        output tx_valid, tx_data, tx_last, miso,
        input  tx_ready, rx_valid, rx_data, busy, done_irq, sck, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_mc.sv
// SPI master with configurable word width, SCK divider, CPOL/CPHA, bit order and slave select.
// Multi-word frames keep the select low between words (WAIT state).
// Optional feature: define SPI_LOOPBACK_EN to let cfg_loopback feed the internal mosi back
// into the receive path instead of the miso pin.
module spi_master_mc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 4,
    parameter int unsigned SS_W   = 2,
    parameter int unsigned DIV_W  = 8
) (
    input logic           clk,
    input logic           rst_n,
    spi_master_mc_if.master bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    localparam int unsigned EDGES = 2 * DATA_W;
    localparam int unsigned EW    = $clog2(EDGES + 1);

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              done_q, done_d;
    logic              sck_q, sck_d;
    logic              last_q, last_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic [NUM_SS-1:0] ss_dec;
    logic              accept, tick, leading, mosi_w, in_bit;

    assign accept = bus.tx_valid && bus.tx_ready;
    assign tick   = (cnt_q == div_q);
    // Even edge index = leading edge (sck moving away from its idle level)
    assign leading = ~edge_q[0];
    assign mosi_w  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];

`ifdef SPI_LOOPBACK_EN
    assign in_bit = bus.cfg_loopback ? mosi_w : bus.miso;
`else
    assign in_bit = bus.miso;
`endif

    // Decode requested select; out-of-range indices leave every select high
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            ss_dec[i] = (bus.cfg_ss_sel != SS_W'(i));
        end
    end

    // Next-state logic for the frame sequencer and shift datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        sck_d      = sck_q;
        last_d     = last_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        ss_n_d     = ss_n_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    tx_sh_d = bus.tx_data;
                    last_d  = bus.tx_last;
                    cpha_d  = bus.cfg_cpha;
                    lsb_d   = bus.cfg_lsb_first;
                    div_d   = bus.cfg_div;
                    sck_d   = bus.cfg_cpol;
                    ss_n_d  = ss_dec;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                    // Preload so the first SCK edge fires one cycle into XFER
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    cnt_d = '0;
                    if (edge_q == EW'(EDGES)) begin
                        state_d    = ST_HOLD;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                    end else begin
                        sck_d  = ~sck_q;
                        edge_d = edge_q + 1'b1;
                        if (cpha_q ? !leading : leading) begin
                            rx_sh_d = lsb_q ? {in_bit, rx_sh_q[DATA_W-1:1]}
                                            : {rx_sh_q[DATA_W-2:0], in_bit};
                        end
                        // First bit is already on mosi, so neither the very first nor the
                        // very last edge shifts
                        if (edge_q != '0 && edge_q != EW'(EDGES - 1) &&
                            (cpha_q ? leading : !leading)) begin
                            tx_sh_d = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]}
                                            : {tx_sh_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                        ss_n_d  = '1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    tx_sh_d = bus.tx_data;
                    last_d  = bus.tx_last;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            sck_q      <= 1'b0;
            last_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            sck_q      <= sck_d;
            last_q     <= last_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            ss_n_q     <= ss_n_d;
        end
    end

    // Outputs; sck follows cfg_cpol live while idle
    always_comb begin
        bus.tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
        bus.busy     = (state_q != ST_IDLE);
        bus.sck      = (state_q == ST_IDLE) ? bus.cfg_cpol : sck_q;
        bus.mosi     = mosi_w;
        bus.ss_n     = ss_n_q;
        bus.rx_valid = rx_valid_q;
        bus.rx_data  = rx_data_q;
        bus.done_irq = done_q;
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: modes, bit order, bursts, reset mid-frame, loopback,
// out-of-range select. Slave model on the bench side drives miso and captures mosi.
module tb_spi_master_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [7:0] tx_w [3];
    logic [7:0] sl_w [3];
    logic [7:0] ex_w [3];

    spi_master_mc_if #(.DATA_W(8), .NUM_SS(4), .SS_W(3), .DIV_W(8)) bus ();

    spi_master_mc #(.DATA_W(8), .NUM_SS(4), .SS_W(3), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic seqbit(input logic [7:0] d, input int i, input logic lsb);
        return lsb ? d[i] : d[7-i];
    endfunction

    // Runs one frame of nw words and checks timing, pins, received and transmitted words.
    task automatic run_frame(input string nm, input logic cpol, input logic cpha,
                             input logic lsb, input int div, input logic [2:0] sel,
                             input int nw, input logic [3:0] exp_ss, input bit chg_sel);
        int   cyc = 0, wi = 0, edges = 0, samples = 0, rxv = 0, dones = 0;
        int   first_edge = -1, rxv_cyc = -1, last_edge = 0;
        bit   accepted = 0, pend, ss_bad = 0, gap_bad = 0;
        logic prev_sck;
        logic [7:0] mo [3];
        logic [7:0] ev;
        for (int i = 0; i < 3; i++) mo[i] = '0;
        @(negedge clk);
        bus.cfg_cpol      = cpol;
        bus.cfg_cpha      = cpha;
        bus.cfg_lsb_first = lsb;
        bus.cfg_div       = 8'(div);
        bus.cfg_ss_sel    = sel;
        bus.miso          = seqbit(sl_w[0], 0, lsb);
        bus.tx_data       = tx_w[0];
        bus.tx_last       = (nw == 1);
        bus.tx_valid      = 1'b1;
        #1;
        check({nm, "_idle_sck"}, 32'(bus.sck), 32'(cpol));
        prev_sck = bus.sck;
        for (int t = 0; t < 3000 && dones == 0; t++) begin
            pend = bus.tx_valid && bus.tx_ready;
            @(negedge clk);
            if (accepted) cyc++;
            if (pend) begin
                if (!accepted) begin
                    accepted = 1;
                    cyc = 0;
                end
                wi++;
                if (wi < nw) begin
                    bus.tx_data = tx_w[wi];
                    bus.tx_last = (wi == nw - 1);
                end else begin
                    bus.tx_valid = 1'b0;
                end
                if (chg_sel) bus.cfg_ss_sel = 3'd0;
            end
            if (accepted && !bus.done_irq && bus.ss_n !== exp_ss) ss_bad = 1;
            if (bus.sck !== prev_sck) begin
                if (first_edge < 0) first_edge = cyc;
                if (edges % 16 != 0 && cyc - last_edge != div + 1) gap_bad = 1;
                last_edge = cyc;
                edges++;
                if ((cpha == 1'b0) ? (bus.sck != cpol) : (bus.sck == cpol)) begin
                    if (samples < nw * 8) mo[samples / 8][samples % 8] = bus.mosi;
                    samples++;
                    if (samples < nw * 8) bus.miso = seqbit(sl_w[samples / 8], samples % 8, lsb);
                end
            end
            prev_sck = bus.sck;
            if (bus.rx_valid) begin
                if (rxv == 0) rxv_cyc = cyc;
                if (rxv < nw) check({nm, "_rx_data"}, 32'(bus.rx_data), 32'(ex_w[rxv]));
                rxv++;
            end
            if (bus.done_irq) dones++;
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.rx_valid) rxv++;
            if (bus.done_irq) dones++;
        end
        check({nm, "_done_cnt"}, 32'(dones), 32'd1);
        check({nm, "_rxv_cnt"}, 32'(rxv), 32'(nw));
        check({nm, "_edges"}, 32'(edges), 32'(16 * nw));
        check({nm, "_first_edge"}, 32'(first_edge), 32'(div + 2));
        check({nm, "_rxv_lat"}, 32'(rxv_cyc), 32'(17 * (div + 1) + 1));
        check({nm, "_ss_hold"}, 32'(ss_bad), 32'd0);
        check({nm, "_sck_gap"}, 32'(gap_bad), 32'd0);
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 8; b++) ev[b] = seqbit(tx_w[i], b, lsb);
            check({nm, "_mosi"}, 32'(mo[i]), 32'(ev));
        end
        check({nm, "_end_ss"}, 32'(bus.ss_n), 32'hF);
        check({nm, "_end_sck"}, 32'(bus.sck), 32'(cpol));
        check({nm, "_end_busy"}, 32'({bus.busy, bus.tx_ready}), 32'b01);
    endtask

    initial begin
        int bad;
        bus.cfg_cpol = 0; bus.cfg_cpha = 0; bus.cfg_lsb_first = 0; bus.cfg_div = 8'd1;
        bus.cfg_ss_sel = 3'd0; bus.cfg_loopback = 0; bus.tx_valid = 0; bus.tx_data = '0;
        bus.tx_last = 0; bus.miso = 0;
        #12;
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_outs", 32'({bus.rx_valid, bus.busy, bus.done_irq, bus.sck, bus.mosi}), 32'd0);
        check("rst_rxdata", 32'(bus.rx_data), 32'd0);
        check("rst_ss", 32'(bus.ss_n), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: mode 0, div 1, select 2
        tx_w[0] = 8'hA5; sl_w[0] = 8'h3C; ex_w[0] = 8'h3C;
        run_frame("t1", 0, 0, 0, 1, 3'd2, 1, 4'b1011, 0);

        // T2: mode 3, LSB first, div 0
        tx_w[0] = 8'h01; sl_w[0] = 8'h96; ex_w[0] = 8'h96;
        run_frame("t2", 1, 1, 1, 0, 3'd0, 1, 4'b1110, 0);

        // T3: three-word burst, select changed mid-burst
        tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
        sl_w[0] = 8'hC1; sl_w[1] = 8'h5E; sl_w[2] = 8'h07;
        ex_w[0] = 8'hC1; ex_w[1] = 8'h5E; ex_w[2] = 8'h07;
        run_frame("t3", 0, 1, 0, 2, 3'd2, 3, 4'b1011, 1);

        // T4: reset in the middle of bit 4
        @(negedge clk);
        bus.cfg_cpol = 0; bus.cfg_cpha = 0; bus.cfg_lsb_first = 0; bus.cfg_div = 8'd1;
        bus.cfg_ss_sel = 3'd1; bus.tx_data = 8'hF0; bus.tx_last = 1; bus.tx_valid = 1;
        @(negedge clk);
        bus.tx_valid = 0;
        repeat (18) @(negedge clk);
        check("t4_midframe_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_rst_ss", 32'(bus.ss_n), 32'hF);
        check("t4_rst_sck", 32'(bus.sck), 32'd0);
        check("t4_rst_ready", 32'(bus.tx_ready), 32'd1);
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            if (bus.rx_valid || bus.done_irq) bad++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            if (bus.rx_valid || bus.done_irq) bad++;
            @(negedge clk);
        end
        check("t4_no_pulse", 32'(bad), 32'd0);
        tx_w[0] = 8'h96; sl_w[0] = 8'h69; ex_w[0] = 8'h69;
        run_frame("t4b", 0, 0, 0, 1, 3'd1, 1, 4'b1101, 0);

        // T5: loopback with miso held low
        bus.cfg_loopback = 1;
        tx_w[0] = 8'hC3; sl_w[0] = 8'h00;
`ifdef SPI_LOOPBACK_EN
        ex_w[0] = 8'hC3;
`else
        ex_w[0] = 8'h00;
`endif
        run_frame("t5", 0, 0, 0, 1, 3'd3, 1, 4'b0111, 0);
        bus.cfg_loopback = 0;

        // T6: select index beyond NUM_SS
        tx_w[0] = 8'h5A; sl_w[0] = 8'hA3; ex_w[0] = 8'hA3;
        run_frame("t6", 0, 0, 0, 1, 3'd7, 1, 4'b1111, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
